latch_bank_wr_ctrl: RTL and testbench

- Write controller and arbiter for a bank of NLAT level-sensitive latch words built from the GTECH D-latch with active-low clear (gate G, clear CD).
- Shares the single latch write port among NREQ requesters using round-robin arbitration.
- Sequences glitch-free, registered gate and clear strobes with programmable setup/gate/hold spacing, so the latches stay transparent only while data is stable.
- Sits between requesting engines and the latch register file; all outputs are registered.

---
 rtl/latch_bank_wr_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_latch_bank_wr_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_wr_ctrl.sv
// -----------------------------------------------------------------------------
// latch_bank_wr_ctrl
//
// Write controller and round-robin arbiter for a bank of NLAT level-sensitive
// latch words (D-latch with active-high gate G and active-low clear CD).
// NREQ requesters share the single latch write port. Each write runs
// SETUP -> GATE -> HOLD so that a gate is only open while D_OUT is stable.
// A bulk clear (CLR_REQ) pulses every CD low for GATE_CYC cycles and takes
// priority over pending writes. All outputs come straight from flops.
//
// Ports
//   CP       in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   REQ      in   [NREQ]     per-requester write request (level, held to ACK)
//   ADDR     in   [NREQ*AW]  word address, requester i at [i*AW +: AW]
//   WDATA    in   [NREQ*DW]  write data,   requester i at [i*DW +: DW]
//   CLR_REQ  in   bulk clear request (level, held to CLR_ACK)
//   ACK      out  [NREQ]     one-hot one-cycle write-complete pulse
//   ERR      out  pulse with ACK when the address is outside the bank
//   CLR_ACK  out  one-cycle bulk-clear-complete pulse
//   BUSY     out  high whenever the FSM is not idle
//   D_OUT    out  [DW]       shared data bus to every latch D input
//   G        out  [NLAT]     per-word latch gate, active-high
//   CD       out  [NLAT]     per-word latch clear, active-low
// -----------------------------------------------------------------------------
module latch_bank_wr_ctrl #(
  parameter int NREQ      = 4,
  parameter int NLAT      = 8,
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int GATE_CYC  = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic               CP,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*AW-1:0] ADDR,
  input  logic [NREQ*DW-1:0] WDATA,
  input  logic               CLR_REQ,
  output logic [NREQ-1:0]    ACK,
  output logic               ERR,
  output logic               CLR_ACK,
  output logic               BUSY,
  output logic [DW-1:0]      D_OUT,
  output logic [NLAT-1:0]    G,
  output logic [NLAT-1:0]    CD
);

  localparam int MAX_SG = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
  localparam int MAX_C  = (MAX_SG > HOLD_CYC) ? MAX_SG : HOLD_CYC;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    GATE  = 3'd2,
    HOLD  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  state_t            state_q,   state_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [PW-1:0]     ptr_q,     ptr_d;
  logic [PW-1:0]     gnt_q,     gnt_d;
  logic [AW-1:0]     addr_q,    addr_d;
  logic [DW-1:0]     d_out_q,   d_out_d;
  logic [NREQ-1:0]   ack_q,     ack_d;
  logic              err_q,     err_d;
  logic              clr_ack_q, clr_ack_d;
  logic              busy_q,    busy_d;
  logic [NLAT-1:0]   g_q,       g_d;
  logic [NLAT-1:0]   cd_q,      cd_d;

  // Round-robin pick: first active request at or after the pointer.
  logic found;
  int   sel_i;

  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned turns this combinational block into latches.
    found = 1'b0;
    sel_i = 0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        sel_i = idx;
      end
    end
  end

  // Next state. Each state's down-counter is loaded with (length-1) on entry
  // and the state is left on the cycle the counter reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    d_out_d = d_out_q;

    unique case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d = CLEAR;
          cnt_d   = CW'(GATE_CYC - 1);
        end else if (found) begin
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          gnt_d   = PW'(sel_i);
          addr_d  = ADDR[sel_i*AW +: AW];
          d_out_d = WDATA[sel_i*DW +: DW];
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = GATE;
          cnt_d   = CW'(GATE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GATE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ptr_d   = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the *next* state so that, once registered, they
  // line up exactly with the state they belong to and never glitch.
  always_comb begin
    g_d   = '0;
    ack_d = '0;
    for (int w = 0; w < NLAT; w++) begin
      g_d[w] = (state_d == GATE) && (int'(addr_d) == w);
    end
    for (int r = 0; r < NREQ; r++) begin
      ack_d[r] = (state_d == HOLD) && (cnt_d == '0) && (int'(gnt_d) == r);
    end
    err_d     = (state_d == HOLD) && (cnt_d == '0) && !(int'(addr_d) < NLAT);
    clr_ack_d = (state_d == CLEAR) && (cnt_d == '0);
    cd_d      = (state_d == CLEAR) ? '0 : '1;
    busy_d    = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      d_out_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      clr_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      g_q       <= '0;
      cd_q      <= '0;  // whole bank held cleared while in reset
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      d_out_q   <= d_out_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      clr_ack_q <= clr_ack_d;
      busy_q    <= busy_d;
      g_q       <= g_d;
      cd_q      <= cd_d;
    end
  end

  assign ACK     = ack_q;
  assign ERR     = err_q;
  assign CLR_ACK = clr_ack_q;
  assign BUSY    = busy_q;
  assign D_OUT   = d_out_q;
  assign G       = g_q;
  assign CD      = cd_q;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latch_bank_wr_ctrl
//
// Directed bench for latch_bank_wr_ctrl. Three instances share clock and
// reset: d_* uses default parameters (with a behavioural latch-bank model),
// o_* has NLAT=6 for out-of-range addresses, t_* has SETUP/GATE/HOLD = 2/3/2.
// Inputs are driven and outputs sampled 1 time unit after the falling edge.
// Cycle c means the c-th cycle after the grant edge.
// -----------------------------------------------------------------------------
module tb_latch_bank_wr_ctrl;

  logic cp  = 1'b0;
  logic rst = 1'b1;
  always #5 cp = ~cp;

  int total = 0;
  int bad   = 0;

  // default instance
  logic [3:0]  d_req = '0;
  logic [11:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_clr = 1'b0;
  logic [3:0]  d_ack;
  logic        d_err, d_clr_ack, d_busy;
  logic [7:0]  d_dout, d_g, d_cd;

  // NLAT=6 instance
  logic [3:0]  o_req = '0;
  logic [11:0] o_addr = '0;
  logic [31:0] o_wdata = '0;
  logic [3:0]  o_ack;
  logic        o_err, o_clr_ack, o_busy;
  logic [7:0]  o_dout;
  logic [5:0]  o_g, o_cd;

  // long-timing instance
  logic [3:0]  t_req = '0;
  logic [11:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [3:0]  t_ack;
  logic        t_err, t_clr_ack, t_busy;
  logic [7:0]  t_dout, t_g, t_cd;

  latch_bank_wr_ctrl u_d (
    .CP(cp), .RST(rst), .REQ(d_req), .ADDR(d_addr), .WDATA(d_wdata),
    .CLR_REQ(d_clr), .ACK(d_ack), .ERR(d_err), .CLR_ACK(d_clr_ack),
    .BUSY(d_busy), .D_OUT(d_dout), .G(d_g), .CD(d_cd)
  );

  latch_bank_wr_ctrl #(.NLAT(6)) u_o (
    .CP(cp), .RST(rst), .REQ(o_req), .ADDR(o_addr), .WDATA(o_wdata),
    .CLR_REQ(1'b0), .ACK(o_ack), .ERR(o_err), .CLR_ACK(o_clr_ack),
    .BUSY(o_busy), .D_OUT(o_dout), .G(o_g), .CD(o_cd)
  );

  latch_bank_wr_ctrl #(.SETUP_CYC(2), .GATE_CYC(3), .HOLD_CYC(2)) u_t (
    .CP(cp), .RST(rst), .REQ(t_req), .ADDR(t_addr), .WDATA(t_wdata),
    .CLR_REQ(1'b0), .ACK(t_ack), .ERR(t_err), .CLR_ACK(t_clr_ack),
    .BUSY(t_busy), .D_OUT(t_dout), .G(t_g), .CD(t_cd)
  );

  // Latch bank model for the default instance: clear dominates, gate loads.
  logic [7:0] mem [8];
  always @(negedge cp) begin
    for (int w = 0; w < 8; w++) begin
      if (!d_cd[w])    mem[w] <= 8'h00;
      else if (d_g[w]) mem[w] <= d_dout;
    end
  end

  // Invariants on the default instance, checked every cycle.
  logic [7:0] prev_dout = '0;
  logic       prev_g_any = 1'b0;
  always @(negedge cp) begin
    total++;
    if ($countones(d_g) > 1 || (d_g != 0 && d_cd != 8'hFF) ||
        (prev_g_any && d_g != 0 && d_dout !== prev_dout)) begin
      bad++;
      $display("FAIL invariant: g=%h cd=%h dout=%h prev_dout=%h", d_g, d_cd, d_dout, prev_dout);
    end
    prev_dout  = d_dout;
    prev_g_any = (d_g != 0);
  end

  task automatic tick();
    @(negedge cp);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (d_g !== 8'h00)  begin bad++; $display("FAIL rst_g got=%h exp=00", d_g); end
    total++; if (d_cd !== 8'h00) begin bad++; $display("FAIL rst_cd got=%h exp=00", d_cd); end
    total++; if (d_dout !== 8'h00 || d_ack !== 4'h0 || d_err !== 1'b0 || d_clr_ack !== 1'b0 || d_busy !== 1'b0) begin
      bad++; $display("FAIL rst_outs got dout=%h ack=%b err=%b clr_ack=%b busy=%b exp all 0", d_dout, d_ack, d_err, d_clr_ack, d_busy);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (d_cd !== 8'hFF) begin bad++; $display("FAIL rel_cd got=%h exp=FF", d_cd); end
    total++; if (o_cd !== 6'h3F || t_cd !== 8'hFF) begin bad++; $display("FAIL rel_cd_other got=%h/%h exp=3F/FF", o_cd, t_cd); end
    total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL rel_busy got=%b exp=0", d_busy); end
  endtask

  task automatic test_single_write();
    d_req = 4'b0010; d_addr[3 +: 3] = 3'd3; d_wdata[8 +: 8] = 8'hA5;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin d_addr[3 +: 3] = 3'd6; d_wdata[8 +: 8] = 8'h5A; end
      total++; if (d_g !== ((c == 2) ? 8'h08 : 8'h00)) begin bad++; $display("FAIL sw_g c=%0d got=%h exp=%h", c, d_g, (c == 2) ? 8'h08 : 8'h00); end
      total++; if (d_ack !== ((c == 3) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL sw_ack c=%0d got=%b", c, d_ack); end
      total++; if (d_err !== 1'b0) begin bad++; $display("FAIL sw_err c=%0d got=%b exp=0", c, d_err); end
      total++; if (d_dout !== 8'hA5) begin bad++; $display("FAIL sw_dout c=%0d got=%h exp=A5", c, d_dout); end
      total++; if (d_busy !== (c <= 3)) begin bad++; $display("FAIL sw_busy c=%0d got=%b exp=%b", c, d_busy, c <= 3); end
      if (c == 3) d_req = 4'b0000;
    end
    total++; if (mem[3] !== 8'hA5) begin bad++; $display("FAIL sw_mem3 got=%h exp=A5", mem[3]); end
    total++; if (mem[6] !== 8'h00) begin bad++; $display("FAIL sw_mem6 got=%h exp=00", mem[6]); end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    d_req = 4'b0100; d_addr[6 +: 3] = 3'd5; d_wdata[16 +: 8] = 8'h99;
    for (int c = 0; c < 10 && !hit; c++) begin
      tick();
      if (d_g[5]) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL ar_wait got=timeout exp=G[5] high");
    end else begin
      #1 rst = 1'b1;
      #1;
      total++; if (d_g !== 8'h00)  begin bad++; $display("FAIL ar_g got=%h exp=00", d_g); end
      total++; if (d_cd !== 8'h00) begin bad++; $display("FAIL ar_cd got=%h exp=00", d_cd); end
      total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", d_busy); end
    end
    d_req = 4'b0000; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    total++; if (d_cd !== 8'hFF || d_busy !== 1'b0 || d_g !== 8'h00) begin
      bad++; $display("FAIL ar_rel got cd=%h busy=%b g=%h exp FF/0/00", d_cd, d_busy, d_g);
    end
    total++; if (mem[3] !== 8'h00) begin bad++; $display("FAIL ar_mem3 got=%h exp=00", mem[3]); end
  endtask

  task automatic test_round_robin();
    int got [4];
    int cyc [4];
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      d_addr[i*3 +: 3]  = 3'(i);
      d_wdata[i*8 +: 8] = 8'h10 + 8'(i);
    end
    d_req = 4'b1111;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      tick();
      if (d_ack != 4'b0000) begin
        for (int i = 3; i >= 0; i--) if (d_ack[i]) got[n] = i;
        d_req[got[n]] = 1'b0;
        cyc[n] = c;
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (got[i] != i) begin bad++; $display("FAIL rr_order slot=%0d got=%0d exp=%0d", i, got[i], i); end
      total++; if (cyc[i] != 3 + 4*i) begin bad++; $display("FAIL rr_cycle slot=%0d got=%0d exp=%0d", i, cyc[i], 3 + 4*i); end
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL rr_mem%0d got=%h exp=%h", i, mem[i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_clear_priority();
    d_clr = 1'b1; d_req = 4'b0001; d_addr[0 +: 3] = 3'd2; d_wdata[0 +: 8] = 8'hC3;
    for (int c = 1; c <= 5; c++) begin
      tick();
      total++; if (d_cd !== ((c == 1) ? 8'h00 : 8'hFF)) begin bad++; $display("FAIL cp_cd c=%0d got=%h", c, d_cd); end
      total++; if (d_clr_ack !== (c == 1)) begin bad++; $display("FAIL cp_clr_ack c=%0d got=%b exp=%b", c, d_clr_ack, c == 1); end
      total++; if (d_g !== ((c == 4) ? 8'h04 : 8'h00)) begin bad++; $display("FAIL cp_g c=%0d got=%h", c, d_g); end
      total++; if (d_ack !== ((c == 5) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL cp_ack c=%0d got=%b", c, d_ack); end
      total++; if (d_busy !== (c != 2)) begin bad++; $display("FAIL cp_busy c=%0d got=%b exp=%b", c, d_busy, c != 2); end
      if (c == 1) begin
        d_clr = 1'b0;
        total++; if (mem[1] !== 8'h00) begin bad++; $display("FAIL cp_cleared got=%h exp=00", mem[1]); end
      end
      if (c == 5) d_req = 4'b0000;
    end
    tick();
    total++; if (mem[2] !== 8'hC3) begin bad++; $display("FAIL cp_mem2 got=%h exp=C3", mem[2]); end
  endtask

  task automatic test_out_of_range();
    o_req = 4'b0100; o_addr[6 +: 3] = 3'd7; o_wdata[16 +: 8] = 8'h77;
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++; if (o_g !== 6'h00) begin bad++; $display("FAIL oor_g c=%0d got=%h exp=00", c, o_g); end
      total++; if (o_ack !== ((c == 3) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL oor_ack c=%0d got=%b", c, o_ack); end
      total++; if (o_err !== (c == 3)) begin bad++; $display("FAIL oor_err c=%0d got=%b exp=%b", c, o_err, c == 3); end
      if (c == 3) o_req = 4'b0000;
    end
    o_req = 4'b0001; o_addr[0 +: 3] = 3'd5; o_wdata[0 +: 8] = 8'h55;
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++; if (o_g !== ((c == 2) ? 6'b100000 : 6'h00)) begin bad++; $display("FAIL oor_in_g c=%0d got=%h", c, o_g); end
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL oor_in_err c=%0d got=%b exp=0", c, o_err); end
      if (c == 3) begin
        total++; if (o_ack !== 4'b0001) begin bad++; $display("FAIL oor_in_ack got=%b exp=0001", o_ack); end
        o_req = 4'b0000;
      end
    end
    tick();
  endtask

  task automatic test_timing();
    t_req = 4'b1000; t_addr[9 +: 3] = 3'd6; t_wdata[24 +: 8] = 8'h3C;
    for (int c = 1; c <= 9; c++) begin
      tick();
      total++; if (t_g !== ((c >= 3 && c <= 5) ? 8'h40 : 8'h00)) begin bad++; $display("FAIL tim_g c=%0d got=%h", c, t_g); end
      total++; if (t_ack !== ((c == 7) ? 4'b1000 : 4'b0000)) begin bad++; $display("FAIL tim_ack c=%0d got=%b", c, t_ack); end
      total++; if (t_busy !== (c <= 7)) begin bad++; $display("FAIL tim_busy c=%0d got=%b exp=%b", c, t_busy, c <= 7); end
      total++; if (t_dout !== 8'h3C) begin bad++; $display("FAIL tim_dout c=%0d got=%h exp=3C", c, t_dout); end
      if (c == 7) t_req = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_async_reset();
    test_round_robin();
    test_clear_priority();
    test_out_of_range();
    test_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
